// File: rtl/scan_cmd_if.sv
// Host-side bundle for scan_chain_ctrl: command, LOAD data stream, READBACK stream and status.
interface scan_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       din_valid;
  logic       din_ready;
  logic       din;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output cmd_valid, cmd_op, din_valid, din, dout_ready,
    input  cmd_ready, din_ready, dout_valid, dout, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, din_valid, din, dout_ready,
    output cmd_ready, din_ready, dout_valid, dout, busy, done, err
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Command sequencer for one scan chain: serial LOAD, recirculating READBACK and timed CLEAR.
// Owns the chain's en, data and clear pins; data paths through it are combinational.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN  = 10,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1),
  parameter int CLR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       clear,
  scan_cmd_if.slave  bus,
  output logic       sc_en,
  output logic       sc_data_o,
  input  logic       sc_data_i,
  output logic       sc_clear_n
);

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CLR_W-1:0] LAST_CLR = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_CLR,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CLR_W-1:0]  clr_cnt_reg, clr_cnt_next;
  logic              err_reg, err_next;
  logic              clr_low;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      clr_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      clr_cnt_reg <= clr_cnt_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    clr_cnt_next   = clr_cnt_reg;
    err_next       = 1'b0;
    clr_low        = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.din_ready  = 1'b0;
    bus.dout_valid = 1'b0;
    bus.dout       = 1'b0;
    bus.busy       = 1'b1;
    bus.done       = 1'b0;
    sc_en          = 1'b0;
    sc_data_o      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        bus.busy      = 1'b0;
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          cnt_next     = '0;
          clr_cnt_next = '0;
          case (bus.cmd_op)
            2'b00:   state_next = S_LOAD;
            2'b01:   state_next = S_READ;
            2'b10:   state_next = S_CLR;
            default: err_next   = 1'b1;
          endcase
        end
      end

      S_LOAD: begin
        bus.din_ready = 1'b1;
        sc_en         = bus.din_valid;
        sc_data_o     = bus.din;
        if (bus.din_valid) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) state_next = S_DONE;
        end
      end

      // The chain output is fed straight back in, so a full pass restores the contents.
      S_READ: begin
        bus.dout_valid = 1'b1;
        bus.dout       = sc_data_i;
        sc_data_o      = sc_data_i;
        sc_en          = bus.dout_ready;
        if (bus.dout_ready) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) state_next = S_DONE;
        end
      end

      S_CLR: begin
        clr_low = 1'b1;
        if (clr_cnt_reg == LAST_CLR) state_next = S_DONE;
        else                         clr_cnt_next = clr_cnt_reg + 1'b1;
      end

      S_DONE: begin
        bus.done   = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.err    = err_reg;
  // Block reset also clears the chain, since an aborted shift leaves it undefined.
  assign sc_clear_n = clear & ~clr_low;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a behavioural 5-flop chain and a readback scoreboard.
module tb_scan_chain_ctrl;
  localparam int LEN = 5;

  logic clk = 1'b0;
  logic clear;
  logic sc_en, sc_data_o, sc_data_i, sc_clear_n;
  logic [LEN-1:0] chain;
  logic [LEN-1:0] last_load;
  logic exp_q[$];
  int checks = 0;
  int failures = 0;

  scan_cmd_if bus ();

  scan_chain_ctrl #(.CHAIN_LEN(LEN), .CLR_CYCLES(2)) dut (
    .clk        (clk),
    .clear      (clear),
    .bus        (bus),
    .sc_en      (sc_en),
    .sc_data_o  (sc_data_o),
    .sc_data_i  (sc_data_i),
    .sc_clear_n (sc_clear_n)
  );

  always #5 clk = ~clk;

  // Chain model: data enters at bit 0, last stage drives sc_data_i.
  always @(posedge clk) begin
    if (!sc_clear_n)  chain <= '0;
    else if (sc_en)   chain <= {chain[LEN-2:0], sc_data_o};
  end
  assign sc_data_i = chain[LEN-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    #1;
    check("cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
  endtask

  task automatic load(input logic [LEN-1:0] bits, input bit gaps, input bit hold_read);
    do_cmd(2'b00);
    if (hold_read) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b01;
    end
    for (int i = 0; i < LEN; i++) begin
      bus.din_valid = 1'b1;
      bus.din       = bits[i];
      #1;
      check("load_en", sc_en, 1);
      check("load_data", sc_data_o, bits[i]);
      check("load_din_ready", bus.din_ready, 1);
      check("load_done_early", bus.done, 0);
      if (hold_read) check("held_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
      if (gaps && i < LEN - 1) begin
        bus.din_valid = 1'b0;
        bus.din       = ~bits[i];
        #1;
        check("gap_en", sc_en, 0);
        check("gap_done", bus.done, 0);
        @(negedge clk);
      end
    end
    bus.din_valid = 1'b0;
    #1;
    check("load_done", bus.done, 1);
    check("load_done_busy", bus.busy, 1);
    check("load_done_cmd_ready", bus.cmd_ready, 0);
    check("load_done_en", sc_en, 0);
    last_load = bits;
    @(negedge clk);
    #1;
    check("load_idle_done", bus.done, 0);
    check("load_idle_busy", bus.busy, 0);
    check("load_idle_cmd_ready", bus.cmd_ready, 1);
  endtask

  task automatic readback(input bit gaps, input bit already_issued);
    logic e;
    if (already_issued) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
    end else begin
      do_cmd(2'b01);
    end
    for (int i = 0; i < LEN; i++) exp_q.push_back(last_load[i]);
    for (int i = 0; i < LEN; i++) begin
      if (gaps) begin
        bus.dout_ready = 1'b0;
        #1;
        check("rb_stall_valid", bus.dout_valid, 1);
        check("rb_stall_en", sc_en, 0);
        @(negedge clk);
      end
      bus.dout_ready = 1'b1;
      #1;
      check("rb_valid", bus.dout_valid, 1);
      check("rb_en", sc_en, 1);
      if (exp_q.size() == 0) begin
        check("rb_queue_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rb_dout", bus.dout, e);
        check("rb_recirc", sc_data_o, e);
      end
      @(negedge clk);
    end
    bus.dout_ready = 1'b0;
    #1;
    check("rb_done", bus.done, 1);
    check("rb_done_valid", bus.dout_valid, 0);
    @(negedge clk);
    #1;
    check("rb_idle_busy", bus.busy, 0);
    check("rb_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'b00;
    bus.din_valid  = 1'b0;
    bus.din        = 1'b0;
    bus.dout_ready = 1'b0;
    last_load      = '0;

    // Reset values
    @(negedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_din_ready", bus.din_ready, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_sc_en", sc_en, 0);
    check("rst_sc_data", sc_data_o, 0);
    check("rst_sc_clear_n", sc_clear_n, 0);
    @(negedge clk);
    clear = 1'b1;
    #1;
    check("run_sc_clear_n", sc_clear_n, 1);

    // Contiguous LOAD of 1,1,0,1,1 then two non-destructive readbacks
    load(5'b11011, 1'b0, 1'b0);
    readback(1'b0, 1'b0);
    readback(1'b0, 1'b0);

    // Gapped LOAD, gapped READBACK
    load(5'b00101, 1'b1, 1'b0);
    readback(1'b1, 1'b0);

    // CLEAR holds sc_clear_n low exactly two cycles
    do_cmd(2'b10);
    #1;
    check("clr_low_1", sc_clear_n, 0);
    check("clr_en", sc_en, 0);
    check("clr_busy", bus.busy, 1);
    @(negedge clk);
    #1;
    check("clr_low_2", sc_clear_n, 0);
    check("clr_no_done", bus.done, 0);
    @(negedge clk);
    #1;
    check("clr_released", sc_clear_n, 1);
    check("clr_done", bus.done, 1);
    @(negedge clk);
    #1;
    check("clr_idle_busy", bus.busy, 0);
    last_load = '0;
    readback(1'b0, 1'b0);

    // Reserved op: err pulse only
    do_cmd(2'b11);
    #1;
    check("err_pulse", bus.err, 1);
    check("err_no_done", bus.done, 0);
    check("err_busy", bus.busy, 0);
    check("err_sc_en", sc_en, 0);
    @(negedge clk);
    #1;
    check("err_cleared", bus.err, 0);

    // READBACK command held through LOAD is taken only after DONE
    load(5'b10110, 1'b0, 1'b1);
    readback(1'b0, 1'b1);

    // Reset after three LOAD bits aborts and clears the chain
    do_cmd(2'b00);
    for (int i = 0; i < 3; i++) begin
      bus.din_valid = 1'b1;
      bus.din       = 1'b1;
      @(negedge clk);
    end
    clear = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_cmd_ready", bus.cmd_ready, 1);
    check("abort_din_ready", bus.din_ready, 0);
    check("abort_sc_en", sc_en, 0);
    check("abort_sc_clear_n", sc_clear_n, 0);
    check("abort_done", bus.done, 0);
    @(negedge clk);
    clear         = 1'b1;
    bus.din_valid = 1'b0;
    load(5'b01001, 1'b0, 1'b0);
    readback(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
